// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the EX stage.
// Works on operand magnitudes and applies signs at the end; divide is a 32-step restoring loop.
module ex_muldiv_unit #(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        flush,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [63:0] hilo_out
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] prod_q, prod_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [63:0] hilo_q, hilo_d;

  logic [63:0] mul_mag, mul_src, mul_res;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] quot_fix, rem_fix, lo_fix;

  assign mul_mag = {32'd0, a_q} * {32'd0, b_q};
  // With a single MUL cycle there is no earlier edge to register the product on.
  assign mul_src = (MUL_STAGES == 1) ? mul_mag : prod_q;
  assign mul_res = (sgn_q & (sign_a_q ^ sign_b_q)) ? neg64(mul_src) : mul_src;

  // a_q doubles as the dividend shift register and collects quotient bits from the right.
  assign rem_sh   = {rem_q, a_q[31]};
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  assign quot_fix = (sgn_q & (sign_a_q ^ sign_b_q)) ? neg32(a_q) : a_q;
  assign rem_fix  = (sgn_q & sign_a_q) ? neg32(rem_q) : rem_q;
  assign lo_fix   = (b_q == 32'd0) ? 32'hFFFF_FFFF : quot_fix;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hilo_d   = hilo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            sgn_d    = ~op[0];
            sign_a_d = ~op[0] & operand_a[31];
            sign_b_d = ~op[0] & operand_b[31];
            a_d      = (~op[0] & operand_a[31]) ? neg32(operand_a) : operand_a;
            b_d      = (~op[0] & operand_b[31]) ? neg32(operand_b) : operand_b;
            rem_d    = 32'd0;
            cnt_d    = 6'd0;
            state_d  = op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          prod_d = mul_mag;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == MUL_LAST) begin
            hilo_d  = mul_res;
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          rem_d = rem_ge ? (rem_sh[31:0] - b_q) : rem_sh[31:0];
          a_d   = {a_q[30:0], rem_ge};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == DIV_LAST) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          hilo_d  = {rem_fix, lo_fix};
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hilo_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hilo_q   <= hilo_d;
    end
  end

  assign stall_req = (start & (state_q == S_IDLE) & ~flush) |
                     (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIXUP);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign hilo_out  = hilo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic/latency model checked every cycle, plus directed literal vectors.
module tb_ex_muldiv_unit;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        flush = 1'b0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        stall_req, busy, done;
  logic [63:0] hilo_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ex_muldiv_unit #(.MUL_STAGES(MS), .DIV_ITERS(32)) dut (
    .clk(clk), .rset(rset), .start(start), .op(op), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall_req(stall_req), .busy(busy), .done(done), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    case (o)
      2'd0: begin
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Timing model: an accepted op finishes a fixed number of cycles later.
  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_hilo = 64'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_cnt = 0;

  always @(posedge clk or posedge rset) begin
    if (rset) begin
      m_active = 1'b0; m_done = 1'b0; m_hilo = 64'd0; m_cnt = 0;
    end else if (flush) begin
      m_active = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else if (m_active && !m_done) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_hilo = m_pend;
      end
    end else begin
      m_done = 1'b0;
      m_active = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_cnt = (op[1] ? 34 : MS + 1) - 1;
        m_pend = model(op, operand_a, operand_b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy", {63'd0, busy}, {63'd0, m_active});
      chk("cmp_done", {63'd0, done}, {63'd0, m_done});
      chk("cmp_stall", {63'd0, stall_req},
          {63'd0, (start & ~m_active & ~flush) | (m_active & ~m_done)});
      chk("cmp_hilo", hilo_out, m_hilo);
    end
  end

  task automatic wait_done(input int k0, output int n, output int st);
    n = -1;
    st = 0;
    for (int k = k0; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
      st += int'(stall_req);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string nm, input bit poke);
    int n, st, s2, k0, lat;
    lat = o[1] ? 34 : MS + 1;
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    st = int'(stall_req);
    @(posedge clk); #1;
    operand_a = $urandom;
    operand_b = $urandom;
    if (poke) begin
      op = ~o;
      @(negedge clk);
      st += int'(stall_req);
      @(posedge clk); #1;
      start = 1'b0;
      k0 = 2;
    end else begin
      start = 1'b0;
      k0 = 1;
    end
    wait_done(k0, n, s2);
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_stall_cycles"}, 64'(st + s2), 64'(lat));
    chk({nm, "_hilo"}, hilo_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, dn;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", hilo_out, 64'd0);
    rset = 1'b0;
    chk_en = 1'b1;

    chk("model_mult", model(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("model_divu", model(2'd3, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
    chk("model_div", model(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, "mult_m3x5", 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minmin", 0);
    run_op(2'd0, 32'd7,         32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, "mult_7xm2", 0);
    run_op(2'd3, 32'd100,       32'd7,        64'h0000_0002_0000_000E, "divu_100_7", 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2_poke", 1);
    run_op(2'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_m2", 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf", 0);
    run_op(2'd3, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, "divu_by0", 0);
    run_op(2'd2, 32'hFFFF_FFF8, 32'd0,        64'hFFFF_FFF8_FFFF_FFFF, "div_by0_neg", 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001, "divu_big", 0);

    // Flush during the tenth divide iteration.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_before", {63'd0, stall_req}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {63'd0, busy}, 64'd0);
    chk("flush_stall_after", {63'd0, stall_req}, 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("flush_no_done", 64'(dn), 64'd0);
    chk("flush_hilo_kept", hilo_out, 64'h7FFF_FFFE_0000_0001);

    // Flush wins over a simultaneous start.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'd0; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    chk("flushprio_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flushprio_busy", {63'd0, busy}, 64'd0);

    // Back-to-back: the next start lands in the DONE cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    chk("b2b_first_done", {63'd0, done}, 64'd1);
    chk("b2b_first_hilo", hilo_out, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, n, s);
    chk("b2b_second_latency", 64'(n), 64'd34);
    chk("b2b_second_hilo", hilo_out, 64'h0000_0002_0000_000E);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; operand_a = 32'd7; operand_b = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    rset = 1'b1;
    #1;
    chk("rst_mid_hilo", hilo_out, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    rset = 1'b0;

    run_op(2'd1, 32'd3, 32'd4, 64'd12, "multu_after_rst", 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
